tt_sel_ctrl: RTL and testbench

TT_SEL_CTRL -- requirements
Module: tt_sel_ctrl

---
 rtl/tt_sel_ctrl_pkg.sv | 37 +++
 rtl/tt_sel_ctrl_if.sv | 32 +++
 rtl/tt_sync_ff.sv | 34 +++
 rtl/tt_sel_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tt_sel_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_sel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tt_sel_ctrl_pkg
// Shared types and helpers for the design-select controller.
//   - sel_state_t : settle/active state of the enable sequencer
//   - width_of()  : index width for a count of n items (never below 1 bit)
// The TT_* geometry defaults are normally provided by tt_defs.vh; the guarded
// definitions below only take effect when that header has not been read first.
// -----------------------------------------------------------------------------
`ifndef TT_G_X
`define TT_G_X 16
`endif
`ifndef TT_G_Y
`define TT_G_Y 4
`endif
`ifndef TT_MUX_MASK
`define TT_MUX_MASK 4'b0010
`endif

package tt_sel_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_ACTIVE = 1'b1
  } sel_state_t;

  // Bits needed to index n items; a single item still gets one bit.
  function automatic int width_of(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tt_sel_ctrl_if.sv
// -----------------------------------------------------------------------------
// tt_sel_ctrl_if
// Pad-side control inputs and selection outputs of tt_sel_ctrl.
//   ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena : asynchronous pad requests
//   sel_addr [ADDR_W]                      : current {branch, block}
//   sel_ena, busy, wrap                    : enable, settling flag, wrap pulse
// master drives the pads (board/bench side), slave is the controller.
// -----------------------------------------------------------------------------
interface tt_sel_ctrl_if #(
  parameter int ADDR_W = 6
);
  import tt_sel_ctrl_pkg::*;

  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ena;
  logic              busy;
  logic              wrap;

  modport master (
    output ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    input  sel_addr, sel_ena, busy, wrap
  );

  modport slave (
    input  ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    output sel_addr, sel_ena, busy, wrap
  );

endinterface

// File: rtl/tt_sync_ff.sv
// -----------------------------------------------------------------------------
// tt_sync_ff
// Single-bit flop-chain synchroniser for an asynchronous pad input.
//   clk, rst_n : block clock, synchronous active-low reset (chain clears to 0)
//   d          : asynchronous input
//   q          : d retimed through STAGES flops
// -----------------------------------------------------------------------------
module tt_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("tt_sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_r;

  // Shift the pad value down the chain, one flop per clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/tt_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tt_sel_ctrl
// Steps a {branch, block} selection through every present user module and
// only enables the selected module once the address has been stable for
// SETTLE cycles.
//   clk   : block clock
//   rst_n : synchronous active-low reset
//   bus   : tt_sel_ctrl_if.slave (pad requests in, selection/enable out)
// Pad inputs are synchronised, the increment edge is registered once before
// it moves the address, and all outputs come straight from flops.
// -----------------------------------------------------------------------------
module tt_sel_ctrl
  import tt_sel_ctrl_pkg::*;
#(
  parameter int              G_X         = `TT_G_X,
  parameter int              G_Y         = `TT_G_Y,
  parameter logic [G_Y-1:0]  MUX_MASK    = `TT_MUX_MASK,
  parameter int              SYNC_STAGES = 2,
  parameter int              SETTLE      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sel_ctrl_if.slave bus
);

  localparam int BLK_W  = width_of(G_X);
  localparam int BR_W   = width_of(G_Y);
  localparam int ADDR_W = BR_W + BLK_W;
  localparam int CNT_W  = width_of(SETTLE);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(G_X - 1);

  // Lowest branch that is physically present.
  function automatic logic [BR_W-1:0] first_br_f();
    logic [BR_W-1:0] br;
    br = {BR_W{1'b0}};
    for (int i = G_Y - 1; i >= 0; i--) begin
      if (!MUX_MASK[i]) begin
        br = BR_W'(i);
      end else begin
        br = br;
      end
    end
    return br;
  endfunction

  // Nearest present branch above cur; MSB flags whether one exists.
  function automatic logic [BR_W:0] next_br_f(input logic [BR_W-1:0] cur);
    logic [BR_W:0] res;
    res = {1'b0, first_br_f()};
    for (int i = G_Y - 1; i >= 0; i--) begin
      if (!MUX_MASK[i] && (i > int'(cur))) begin
        res = {1'b1, BR_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  localparam logic [ADDR_W-1:0] FIRST = {first_br_f(), {BLK_W{1'b0}}};

  if (MUX_MASK == {G_Y{1'b1}}) begin : g_bad_mask
    $error("tt_sel_ctrl: MUX_MASK removes every branch");
  end
  if ((G_X < 2) || ((G_X & (G_X - 1)) != 0)) begin : g_bad_gx
    $error("tt_sel_ctrl: G_X must be a power of two, at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tt_sel_ctrl: SYNC_STAGES must be at least 2");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("tt_sel_ctrl: SETTLE must be at least 1");
  end

  logic s_rst_n;
  logic s_inc;
  logic s_ena;

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk(clk), .rst_n(rst_n), .d(bus.ctrl_sel_rst_n), .q(s_rst_n)
  );
  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk(clk), .rst_n(rst_n), .d(bus.ctrl_sel_inc), .q(s_inc)
  );
  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ena (
    .clk(clk), .rst_n(rst_n), .d(bus.ctrl_ena), .q(s_ena)
  );

  logic              inc_prev_r;
  logic              inc_evt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic              wrap_s;
  logic              chg_s;
  logic [BR_W:0]     nb_s;
  sel_state_t        state_r;
  sel_state_t        state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              sel_ena_r;
  logic              busy_r;
  logic              wrap_r;

  // Capture rising edges of the synchronised increment; an edge seen while the
  // selection reset is low is dropped so the reset always wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_prev_r <= 1'b0;
      inc_evt_r  <= 1'b0;
    end else begin
      inc_prev_r <= s_inc;
      inc_evt_r  <= s_inc & ~inc_prev_r & s_rst_n;
    end
  end

  // Next selection: reset to FIRST, step the block, or hop to the next branch.
  always_comb begin
    addr_s = addr_r;
    wrap_s = 1'b0;
    chg_s  = 1'b0;
    nb_s   = next_br_f(addr_r[ADDR_W-1:BLK_W]);
    if (!s_rst_n) begin
      addr_s = FIRST;
      chg_s  = 1'b1;
    end else if (inc_evt_r) begin
      chg_s = 1'b1;
      if (addr_r[BLK_W-1:0] != BLK_LAST) begin
        addr_s = {addr_r[ADDR_W-1:BLK_W], addr_r[BLK_W-1:0] + BLK_W'(1)};
      end else if (nb_s[BR_W]) begin
        addr_s = {nb_s[BR_W-1:0], {BLK_W{1'b0}}};
      end else begin
        addr_s = FIRST;
        wrap_s = 1'b1;
      end
    end else begin
      addr_s = addr_r;
    end
  end

  // Settle sequencer: any address change restarts the countdown.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (chg_s) begin
      state_s = ST_SETTLE;
      cnt_s   = CNT_INIT;
    end else begin
      case (state_r)
        ST_SETTLE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_s = ST_ACTIVE;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          state_s = ST_ACTIVE;
        end
        default: begin
          state_s = ST_SETTLE;
          cnt_s   = CNT_INIT;
        end
      endcase
    end
  end

  // Address, sequencer state and outputs. The enable is formed from the next
  // state so it rises on the same edge the sequencer enters ACTIVE, giving
  // exactly SETTLE disabled cycles after each change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r    <= FIRST;
      state_r   <= ST_SETTLE;
      cnt_r     <= CNT_INIT;
      sel_ena_r <= 1'b0;
      busy_r    <= 1'b1;
      wrap_r    <= 1'b0;
    end else begin
      addr_r    <= addr_s;
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      sel_ena_r <= s_ena & (state_s == ST_ACTIVE);
      busy_r    <= (state_s == ST_SETTLE);
      wrap_r    <= wrap_s;
    end
  end

  assign bus.sel_addr = addr_r;
  assign bus.sel_ena  = sel_ena_r;
  assign bus.busy     = busy_r;
  assign bus.wrap     = wrap_r;

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_sel_ctrl
// Directed bench for tt_sel_ctrl (G_X=16, G_Y=4, MUX_MASK=4'b0010,
// SYNC_STAGES=2, SETTLE=4). A behavioural model walks an ordered list of the
// present addresses and counts cycles since the last change; a compare
// process checks every output against it on each falling edge, and the main
// sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tt_sel_ctrl;

  localparam int SETTLE = 4;

  logic clk;
  logic rst_n;

  tt_sel_ctrl_if #(.ADDR_W(6)) bus ();

  tt_sel_ctrl #(
    .G_X(16), .G_Y(4), .MUX_MASK(4'b0010), .SYNC_STAGES(2), .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wrap_cnt = 0;
  bit model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  int   valid_q[$];
  int   m_idx, m_since;
  bit   m_pend, m_prev;
  bit   m_p1_rst, m_p1_inc, m_p1_ena;
  bit   m_s_rst, m_s_inc, m_s_ena;
  logic [5:0] exp_addr;
  logic exp_ena, exp_busy, exp_wrap;

  task automatic model_step();
    if (!rst_n) begin
      {m_p1_rst, m_p1_inc, m_p1_ena} = 3'b000;
      {m_s_rst, m_s_inc, m_s_ena}    = 3'b000;
      m_prev = 1'b0; m_pend = 1'b0;
      m_idx = 0; m_since = 0;
      exp_wrap = 1'b0; exp_ena = 1'b0; exp_busy = 1'b1;
    end else begin
      exp_wrap = 1'b0;
      if (!m_s_rst) begin
        m_idx = 0; m_since = 0;
      end else if (m_pend) begin
        if (m_idx == valid_q.size() - 1) begin
          m_idx = 0; exp_wrap = 1'b1;
        end else begin
          m_idx++;
        end
        m_since = 0;
      end else if (m_since < SETTLE) begin
        m_since++;
      end
      m_pend = m_s_inc && !m_prev && m_s_rst;
      m_prev = m_s_inc;
      exp_busy = (m_since < SETTLE);
      exp_ena  = m_s_ena && (m_since >= SETTLE);
      {m_s_rst, m_s_inc, m_s_ena} = {m_p1_rst, m_p1_inc, m_p1_ena};
      {m_p1_rst, m_p1_inc, m_p1_ena} = {bus.ctrl_sel_rst_n, bus.ctrl_sel_inc, bus.ctrl_ena};
    end
    exp_addr = 6'(valid_q[m_idx]);
  endtask

  initial begin
    logic [3:0] mask;
    mask = 4'b0010;
    for (int br = 0; br < 4; br++) begin
      if (!mask[br]) begin
        for (int blk = 0; blk < 16; blk++) valid_q.push_back(br * 16 + blk);
      end
    end
    forever begin
      @(posedge clk);
      model_step();
      model_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("sel_addr", {26'd0, bus.sel_addr}, {26'd0, exp_addr});
        check("sel_ena",  {31'd0, bus.sel_ena},  {31'd0, exp_ena});
        check("busy",     {31'd0, bus.busy},     {31'd0, exp_busy});
        check("wrap",     {31'd0, bus.wrap},     {31'd0, exp_wrap});
        if (bus.wrap === 1'b1) wrap_cnt++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ena_low, busy_hi;
    bit found;

    rst_n = 1'b0;
    bus.ctrl_sel_rst_n = 1'b1;
    bus.ctrl_sel_inc   = 1'b0;
    bus.ctrl_ena       = 1'b1;

    // Pin the model's address list.
    check("model_len",   32'(valid_q.size()), 32'd48);
    check("model_at16",  32'(valid_q[16]), 32'h20);
    check("model_last",  32'(valid_q[47]), 32'h3F);

    // Reset state, then release with pads high.
    tick(3);
    check("rst_addr", {26'd0, bus.sel_addr}, 32'h00);
    check("rst_ena",  {31'd0, bus.sel_ena},  32'd0);
    check("rst_busy", {31'd0, bus.busy},     32'd1);
    check("rst_wrap", {31'd0, bus.wrap},     32'd0);
    rst_n = 1'b1;
    tick(5);
    check("ena_before_settle", {31'd0, bus.sel_ena}, 32'd0);
    tick(1);
    check("ena_after_settle",  {31'd0, bus.sel_ena}, 32'd1);
    check("addr_after_rst",    {26'd0, bus.sel_addr}, 32'h00);

    // 16 increments: 0x01..0x0F then branch 1 is skipped to 0x20.
    for (int k = 0; k < 16; k++) begin
      bus.ctrl_sel_inc = 1'b1; tick(2);
      bus.ctrl_sel_inc = 1'b0; tick(2);
      check("skip_step", {26'd0, bus.sel_addr}, (k < 15) ? 32'(k + 1) : 32'h20);
    end
    check("skip_no_wrap", 32'(wrap_cnt), 32'd0);

    // Walk to 0x3F, then one more increment wraps to 0x00.
    for (int k = 0; k < 31; k++) begin
      bus.ctrl_sel_inc = 1'b1; tick(2);
      bus.ctrl_sel_inc = 1'b0; tick(2);
    end
    check("at_3f", {26'd0, bus.sel_addr}, 32'h3F);
    bus.ctrl_sel_inc = 1'b1; tick(2);
    bus.ctrl_sel_inc = 1'b0; tick(6);
    check("wrap_addr",  {26'd0, bus.sel_addr}, 32'h00);
    check("wrap_count", 32'(wrap_cnt), 32'd1);

    // Two increments two cycles apart restart the settle count.
    tick(4);
    ena_low = 0; busy_hi = 0;
    for (int i = 0; i < 16; i++) begin
      bus.ctrl_sel_inc = (i == 0 || i == 2);
      tick(1);
      if (bus.sel_ena === 1'b0) ena_low++;
      if (bus.busy === 1'b1) busy_hi++;
    end
    check("restart_ena_low", 32'(ena_low), 32'd6);
    check("restart_busy",    32'(busy_hi), 32'd6);
    check("restart_addr",    {26'd0, bus.sel_addr}, 32'h02);

    // Selection reset and an increment edge arriving together: reset wins.
    bus.ctrl_sel_rst_n = 1'b0; bus.ctrl_sel_inc = 1'b1; tick(1);
    bus.ctrl_sel_rst_n = 1'b1; tick(1);
    bus.ctrl_sel_inc = 1'b0; tick(8);
    check("prio_addr", {26'd0, bus.sel_addr}, 32'h00);

    // Dropping the enable request in ACTIVE drops sel_ena only.
    bus.ctrl_ena = 1'b0; tick(3);
    check("ena_drop",      {31'd0, bus.sel_ena}, 32'd0);
    check("ena_drop_busy", {31'd0, bus.busy},    32'd0);
    bus.ctrl_ena = 1'b1; tick(4);

    // Mid-settle block reset at 0x25.
    for (int k = 0; k < 21; k++) begin
      bus.ctrl_sel_inc = 1'b1; tick(1);
      bus.ctrl_sel_inc = 1'b0; tick(1);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.sel_addr === 6'h25) found = 1'b1;
      else tick(1);
    end
    check("reach_0x25", {31'd0, found}, 32'd1);
    rst_n = 1'b0; tick(1);
    check("midrst_addr", {26'd0, bus.sel_addr}, 32'h00);
    check("midrst_busy", {31'd0, bus.busy},     32'd1);
    check("midrst_ena",  {31'd0, bus.sel_ena},  32'd0);
    rst_n = 1'b1; tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
